// File: rtl/sw_step_conditioner.sv
// Synchronizes and debounces the SW push-button and Mode switch, and turns
// button presses into single-cycle Step pulses with hold-to-auto-repeat.
module sw_step_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk_50M,
    input  logic Reset,
    input  logic SW_raw,
    input  logic Mode_raw,
    output logic Mode,
    output logic SW_level,
    output logic Step
);
    // state    | meaning
    // S_IDLE   | waiting for a press edge of SW_level while in manual mode
    // S_HELD   | press Step issued, timing the hold delay
    // S_REPEAT | button still held, issuing a Step every REPEAT_CYCLES

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_REPEAT} state_t;

    logic          sw_sync1_q, sw_sync1_d, sw_sync2_q, sw_sync2_d;
    logic          mode_sync1_q, mode_sync1_d, mode_sync2_q, mode_sync2_d;
    logic [DW-1:0] sw_cnt_q, sw_cnt_d, mode_cnt_q, mode_cnt_d;
    logic          sw_level_q, sw_level_d, mode_q, mode_d;
    state_t        state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          step_q, step_d;
    logic          sw_rise;

    always_comb begin
        sw_sync1_d   = SW_raw;
        sw_sync2_d   = sw_sync1_q;
        mode_sync1_d = Mode_raw;
        mode_sync2_d = mode_sync1_q;

        sw_level_d = sw_level_q;
        sw_cnt_d   = '0;
        if (sw_sync2_q != sw_level_q) begin
            if (sw_cnt_q == DB_LAST) sw_level_d = ~sw_level_q;
            else                     sw_cnt_d   = sw_cnt_q + 1'b1;
        end

        mode_d     = mode_q;
        mode_cnt_d = '0;
        if (mode_sync2_q != mode_q) begin
            if (mode_cnt_q == DB_LAST) mode_d     = ~mode_q;
            else                       mode_cnt_d = mode_cnt_q + 1'b1;
        end

        // Decisions use the next debounced levels so Step lands on the same
        // edge as SW_level; a press counts only if Mode was and stays manual.
        sw_rise    = sw_level_d & ~sw_level_q;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        step_d     = 1'b0;

        if (mode_d || !sw_level_d) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (sw_rise && !mode_q) begin
                        state_d    = S_HELD;
                        step_d     = 1'b1;
                        hold_cnt_d = '0;
                    end
                end
                S_HELD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d   = S_REPEAT;
                        step_d    = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (rep_cnt_q == REP_LAST) begin
                        step_d    = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50M or posedge Reset) begin
        if (Reset) begin
            sw_sync1_q   <= 1'b0;
            sw_sync2_q   <= 1'b0;
            mode_sync1_q <= 1'b1;
            mode_sync2_q <= 1'b1;
            sw_cnt_q     <= '0;
            mode_cnt_q   <= '0;
            sw_level_q   <= 1'b0;
            mode_q       <= 1'b1;
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            step_q       <= 1'b0;
        end else begin
            sw_sync1_q   <= sw_sync1_d;
            sw_sync2_q   <= sw_sync2_d;
            mode_sync1_q <= mode_sync1_d;
            mode_sync2_q <= mode_sync2_d;
            sw_cnt_q     <= sw_cnt_d;
            mode_cnt_q   <= mode_cnt_d;
            sw_level_q   <= sw_level_d;
            mode_q       <= mode_d;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            rep_cnt_q    <= rep_cnt_d;
            step_q       <= step_d;
        end
    end

    assign Mode     = mode_q;
    assign SW_level = sw_level_q;
    assign Step     = step_q;

endmodule
